sint_add_rr_scheduler: RTL and testbench

- Shares one signed WIDTH-bit wrap-around adder (in0 + in1 -> out, no carry) among N_REQ requesters.
- Requesters present operand pairs over valid/ready. A round-robin arbiter grants one requester per cycle.
- The result leaves through a single registered response port, with requester ID and signed-overflow flag.
- Sits between the requesters and the shared adder instance. The adder itself stays purely combinational, instantiated inside this block.

---
 rtl/sint_add_sched_pkg.sv | 18 +
 rtl/sint_add.sv | 10 +
 rtl/sint_add_rr_scheduler_rr_arbiter.sv | 36 +++
 rtl/sint_add_rr_scheduler.sv | 57 +++++
 tb/tb_sint_add_rr_scheduler.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/sint_add_sched_pkg.sv
// sint_add_sched_pkg: shared constants and helpers for the round-robin adder scheduler
package sint_add_sched_pkg;
    localparam int DEFAULT_N_REQ = 4;
    localparam int DEFAULT_WIDTH = 3;
    localparam int GRANT_CNT_W = 16;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

    // Signed overflow from sign bits only: equal operand signs, differing sum sign
    function automatic logic signed_add_ovf(input logic a, input logic b, input logic sum);
        return (a == b) && (sum != a);
    endfunction
endpackage

// File: rtl/sint_add.sv
// sint_add: width-parameterised wrap-around adder, purely combinational
module sint_add #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] out
);
    assign out = in0 + in1;
endmodule

// File: rtl/sint_add_rr_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin grant starting at ptr; ptr moves past the winner only on advance
module rr_arbiter import sint_add_sched_pkg::*; #(
    parameter int N_REQ = DEFAULT_N_REQ,
    localparam int ID_W = clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             enable,
    input  logic             advance,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx
);
    logic [ID_W-1:0] ptr;
    logic found;
    int j;

    always_comb begin
        grant = '0;
        grant_idx = '0;
        found = 1'b0;
        j = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(ptr) + k) % N_REQ;
            if (enable && !found && req[j]) begin
                found = 1'b1;
                grant[j] = 1'b1;
                grant_idx = ID_W'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ptr <= '0;
        else if (advance) ptr <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
endmodule

// File: rtl/sint_add_rr_scheduler.sv
// sint_add_rr_scheduler: shares one signed wrap-around adder among N_REQ requesters
// via round-robin arbitration into a single registered response slot.
module sint_add_rr_scheduler import sint_add_sched_pkg::*; #(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int ID_W = clog2(N_REQ)
) (
    input  logic                   CLK,
    input  logic                   ASYNCRESETN,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [WIDTH-1:0]       resp_sum,
    output logic [ID_W-1:0]        resp_id,
    output logic                   resp_ovf,
    output logic [GRANT_CNT_W-1:0] grant_count
);
    logic [ID_W-1:0] gidx;
    logic [WIDTH-1:0] a_sel, b_sel, sum;
    logic can_accept, xfer;

    // Gating with reset keeps req_ready low while the slot is forced empty
    assign can_accept = ASYNCRESETN && (!resp_valid || resp_ready);
    assign xfer = |req_ready;
    assign a_sel = req_a[gidx*WIDTH +: WIDTH];
    assign b_sel = req_b[gidx*WIDTH +: WIDTH];

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk(CLK),
        .rst_n(ASYNCRESETN),
        .req(req_valid),
        .enable(can_accept),
        .advance(xfer),
        .grant(req_ready),
        .grant_idx(gidx)
    );

    sint_add #(.WIDTH(WIDTH)) u_add (.in0(a_sel), .in1(b_sel), .out(sum));

    always_ff @(posedge CLK or negedge ASYNCRESETN)
        if (!ASYNCRESETN) begin
            resp_valid <= 1'b0;
            resp_sum <= '0;
            resp_id <= '0;
            resp_ovf <= 1'b0;
            grant_count <= '0;
        end else if (xfer) begin
            resp_valid <= 1'b1;
            resp_sum <= sum;
            resp_id <= gidx;
            resp_ovf <= signed_add_ovf(a_sel[WIDTH-1], b_sel[WIDTH-1], sum[WIDTH-1]);
            grant_count <= grant_count + 1'b1;
        end else if (resp_ready) resp_valid <= 1'b0;
endmodule

// File: tb/tb_sint_add_rr_scheduler.sv
// tb_sint_add_rr_scheduler: directed table-driven and sequence checks for the scheduler
module tb_sint_add_rr_scheduler;
    localparam int N = 4;
    localparam int W = 3;

    logic CLK = 1'b0;
    logic ASYNCRESETN;
    logic [N-1:0] req_valid, req_ready;
    logic [N*W-1:0] req_a, req_b;
    logic resp_valid, resp_ready, resp_ovf;
    logic [W-1:0] resp_sum;
    logic [1:0] resp_id;
    logic [15:0] grant_count;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cnt = 0;

    typedef struct {
        int rid;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum;
        logic ovf;
    } vec_t;
    vec_t vecs[9];

    sint_add_rr_scheduler #(.N_REQ(N), .WIDTH(W)) dut (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_sum(resp_sum), .resp_id(resp_id), .resp_ovf(resp_ovf),
        .grant_count(grant_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_op(input int rid, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[rid*W +: W] = a;
        req_b[rid*W +: W] = b;
    endtask

    initial begin
        vecs[0] = '{2, 3'd3, 3'd1, 3'b100, 1'b1};
        vecs[1] = '{0, 3'b100, 3'b111, 3'b011, 1'b1};
        vecs[2] = '{0, 3'b110, 3'd1, 3'b111, 1'b0};
        vecs[3] = '{1, 3'd2, 3'b101, 3'b111, 1'b0};
        vecs[4] = '{3, 3'd1, 3'd1, 3'b010, 1'b0};
        vecs[5] = '{3, 3'b110, 3'b110, 3'b100, 1'b0};
        vecs[6] = '{1, 3'd3, 3'd3, 3'b110, 1'b1};
        vecs[7] = '{2, 3'b100, 3'b100, 3'b000, 1'b1};
        vecs[8] = '{0, 3'd0, 3'd0, 3'd0, 1'b0};

        ASYNCRESETN = 1'b0;
        req_valid = '1;
        req_a = '0;
        req_b = '0;
        resp_ready = 1'b1;
        #2;
        chk("rst_ready", req_ready, 0);
        chk("rst_valid", resp_valid, 0);
        chk("rst_sum", resp_sum, 0);
        chk("rst_id", resp_id, 0);
        chk("rst_ovf", resp_ovf, 0);
        chk("rst_cnt", grant_count, 0);
        step();
        step();
        ASYNCRESETN = 1'b1;
        req_valid = '0;

        foreach (vecs[v]) begin
            set_op(vecs[v].rid, vecs[v].a, vecs[v].b);
            req_valid = N'(1) << vecs[v].rid;
            #1;
            chk("vec_ready", req_ready, N'(1) << vecs[v].rid);
            step();
            req_valid = '0;
            exp_cnt++;
            chk("vec_valid", resp_valid, 1);
            chk("vec_sum", resp_sum, vecs[v].sum);
            chk("vec_id", resp_id, vecs[v].rid);
            chk("vec_ovf", resp_ovf, vecs[v].ovf);
            chk("vec_cnt", grant_count, exp_cnt);
        end

        // mid-cycle reset with a held response
        resp_ready = 1'b0;
        set_op(1, 3'd1, 3'd1);
        req_valid = 4'b0010;
        step();
        chk("pre_rst_valid", resp_valid, 1);
        #2;
        ASYNCRESETN = 1'b0;
        req_valid = '1;
        #1;
        chk("async_valid", resp_valid, 0);
        chk("async_sum", resp_sum, 0);
        chk("async_cnt", grant_count, 0);
        chk("async_ready", req_ready, 0);
        step();
        chk("rst_hold_ready", req_ready, 0);
        ASYNCRESETN = 1'b1;
        resp_ready = 1'b1;
        exp_cnt = 0;

        // round robin with all valid, first grant to lowest index
        for (int i = 0; i < N; i++) set_op(i, 3'(i), 3'd1);
        req_valid = '1;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("rr_ready", req_ready, N'(1) << (c % N));
            step();
            exp_cnt++;
            chk("rr_valid", resp_valid, 1);
            chk("rr_id", resp_id, c % N);
            chk("rr_sum", resp_sum, ((c % N) + 1) & 7);
        end
        chk("rr_cnt", grant_count, 6);

        // backpressure: response from requester 0 held, 1 and 3 pending
        set_op(0, 3'd1, 3'd2);
        req_valid = 4'b0001;
        step();
        exp_cnt++;
        chk("bp_id0", resp_id, 0);
        resp_ready = 1'b0;
        set_op(1, 3'd1, 3'd1);
        set_op(3, 3'b111, 3'b111);
        req_valid = 4'b1010;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_ready", req_ready, 0);
            step();
            chk("bp_valid", resp_valid, 1);
            chk("bp_id", resp_id, 0);
            chk("bp_sum", resp_sum, 3);
            chk("bp_cnt", grant_count, exp_cnt);
        end
        resp_ready = 1'b1;
        #1;
        chk("refill_ready1", req_ready, 4'b0010);
        step();
        exp_cnt++;
        chk("refill_valid", resp_valid, 1);
        chk("refill_id1", resp_id, 1);
        chk("refill_sum1", resp_sum, 2);
        req_valid = 4'b1000;
        #1;
        chk("refill_ready3", req_ready, 4'b1000);
        step();
        exp_cnt++;
        chk("refill_id3", resp_id, 3);
        chk("refill_sum3", resp_sum, 3'b110);
        chk("refill_ovf3", resp_ovf, 0);
        req_valid = '0;
        step();
        chk("drain_valid", resp_valid, 0);
        chk("drain_cnt", grant_count, exp_cnt);

        // idle cycles do not move ptr (0 after grant to 3)
        for (int c = 0; c < 5; c++) begin
            step();
            chk("idle_valid", resp_valid, 0);
        end
        req_valid = 4'b0011;
        #1;
        chk("idle_ready0", req_ready, 4'b0001);
        step();
        exp_cnt++;
        chk("idle_id0", resp_id, 0);
        req_valid = 4'b0100;
        step();
        exp_cnt++;
        chk("idle_id2", resp_id, 2);
        req_valid = '0;
        for (int c = 0; c < 5; c++) step();
        req_valid = '1;
        #1;
        chk("idle_ready3", req_ready, 4'b1000);
        step();
        exp_cnt++;
        chk("idle_id3", resp_id, 3);
        chk("final_cnt", grant_count, exp_cnt);
        req_valid = '0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
